// File: rtl/vend_pkg.sv
// Shared types and constants for the vending purchase path.
// Holds the result codes reported to the panel, the purchase FSM state
// encoding, and the fixed per-item price table (item 0 is invalid).
package vend_pkg;

    typedef enum logic [1:0] {
        RES_NONE     = 2'b00,
        RES_OK       = 2'b01,
        RES_SOLD_OUT = 2'b10,
        RES_DENIED   = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        DECIDE,
        DISPENSE,
        DONE
    } state_t;

    localparam logic [15:0] PRICE [8] = '{
        16'd0, 16'd5, 16'd10, 16'd15, 16'd20, 16'd25, 16'd30, 16'd50
    };

    function automatic logic [15:0] price_of(input logic [2:0] item);
        return PRICE[item];
    endfunction

endpackage

// File: rtl/stock_bank.sv
// Per-item stock counters (8 x 4-bit).
//   clk, rst_n : clock, asynchronous active-low reset (loads INIT)
//   dec        : decrement the counter selected by idx (saturates at 0)
//   idx        : item index for decrement and for the count read port
//   restock    : reload every counter with INIT; overrides a same-cycle dec
//   count      : current stock of item idx
//   empty      : bit i set when stock of item i is zero; bit 0 is forced 1
module stock_bank #(
    parameter logic [3:0] INIT = 4'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec,
    input  logic [2:0] idx,
    input  logic       restock,
    output logic [3:0] count,
    output logic [7:0] empty
);

    logic [3:0] cnt [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                cnt[i] <= INIT;
            end
        end else if (restock) begin
            for (int unsigned i = 0; i < 8; i++) begin
                cnt[i] <= INIT;
            end
        end else if (dec && (cnt[idx] != '0)) begin
            cnt[idx] <= cnt[idx] - 4'd1;
        end
    end

    assign count = cnt[idx];

    // Item 0 is not a sellable slot, so it always reports empty.
    always_comb begin
        empty = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            empty[i] = (cnt[i] == '0);
        end
        empty[0] = 1'b1;
    end

endmodule

// File: rtl/purchase_ctrl.sv
// Purchase initiator: takes a panel selection, checks stock, queries the
// user payment block with item id and price, and on a paid answer strobes
// the dispenser and consumes one unit of stock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sel_valid    : selection strobe, only honoured in IDLE
//   sel_item     : selected item (0 = invalid)
//   restock      : reload all stock counters (any state)
//   user_id      : item id to payment block, non-zero only while querying
//   user_price   : item price to payment block, non-zero only while querying
//   user_state   : payment answer, 1 = paid
//   user_change  : change amount from payment block
//   busy         : transaction in progress
//   dispense     : dispense strobe, DISP_CYC cycles long
//   disp_item    : item being dispensed, valid with dispense
//   done         : one-cycle end-of-transaction pulse
//   result       : outcome code, held until the next accepted selection
//   change_out   : change passed through on OK, held with result
//   stock_empty  : per-item empty flags
module purchase_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned WAIT_CYC   = 2,
    parameter int unsigned DISP_CYC   = 4,
    parameter logic [3:0]  STOCK_INIT = 4'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel_valid,
    input  logic [2:0]  sel_item,
    input  logic        restock,
    output logic [2:0]  user_id,
    output logic [15:0] user_price,
    input  logic        user_state,
    input  logic [15:0] user_change,
    output logic        busy,
    output logic        dispense,
    output logic [2:0]  disp_item,
    output logic        done,
    output logic [1:0]  result,
    output logic [15:0] change_out,
    output logic [7:0]  stock_empty
);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [2:0]  item, item_d;
    result_t     res_q, res_d;
    logic [15:0] chg_q, chg_d;
    logic        done_q;
    logic        dec;
    logic [2:0]  stock_idx;
    logic [3:0]  stock_count;

    stock_bank #(.INIT(STOCK_INIT)) u_stock (
        .clk     (clk),
        .rst_n   (rst_n),
        .dec     (dec),
        .idx     (stock_idx),
        .restock (restock),
        .count   (stock_count),
        .empty   (stock_empty)
    );

    // done is registered off the DONE state, so it appears the cycle after
    // DONE is entered; this gives the 1 / 4 / 8 cycle accept-to-done latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            item   <= '0;
            res_q  <= RES_NONE;
            chg_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            item   <= item_d;
            res_q  <= res_d;
            chg_q  <= chg_d;
            done_q <= (state == DONE);
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        item_d    = item;
        res_d     = res_q;
        chg_d     = chg_q;
        dec       = 1'b0;
        stock_idx = item;
        case (state)
            IDLE: begin
                // Stock lookup must use the incoming selection before it is latched.
                stock_idx = sel_item;
                if (sel_valid) begin
                    item_d = sel_item;
                    res_d  = RES_NONE;
                    chg_d  = '0;
                    cnt_d  = '0;
                    if (sel_item == '0) begin
                        res_d   = RES_DENIED;
                        state_d = DONE;
                    end else if (stock_count == '0) begin
                        res_d   = RES_SOLD_OUT;
                        state_d = DONE;
                    end else begin
                        state_d = QUERY;
                    end
                end
            end
            QUERY: begin
                if (cnt == 16'(WAIT_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            DECIDE: begin
                if (user_state) begin
                    res_d   = RES_OK;
                    chg_d   = user_change;
                    dec     = 1'b1;
                    state_d = DISPENSE;
                end else begin
                    res_d   = RES_DENIED;
                    chg_d   = '0;
                    state_d = DONE;
                end
            end
            DISPENSE: begin
                if (cnt == 16'(DISP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign user_id    = (state == QUERY) ? item : '0;
    assign user_price = (state == QUERY) ? price_of(item) : '0;
    assign dispense   = (state == DISPENSE);
    assign disp_item  = (state == DISPENSE) ? item : '0;
    assign done       = done_q;
    assign result     = res_q;
    assign change_out = chg_q;

endmodule

// File: tb/tb_purchase_ctrl.sv
module tb_purchase_ctrl;

    localparam int WAIT  = 2;
    localparam int DISP  = 4;
    localparam int SINIT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel_valid = 1'b0;
    logic [2:0]  sel_item = '0;
    logic        restock = 1'b0;
    logic        user_state = 1'b0;
    logic [15:0] user_change = '0;
    logic [2:0]  user_id;
    logic [15:0] user_price;
    logic        busy;
    logic        dispense;
    logic [2:0]  disp_item;
    logic        done;
    logic [1:0]  result;
    logic [15:0] change_out;
    logic [7:0]  stock_empty;

    purchase_ctrl #(.WAIT_CYC(WAIT), .DISP_CYC(DISP), .STOCK_INIT(4'd5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_valid   (sel_valid),
        .sel_item    (sel_item),
        .restock     (restock),
        .user_id     (user_id),
        .user_price  (user_price),
        .user_state  (user_state),
        .user_change (user_change),
        .busy        (busy),
        .dispense    (dispense),
        .disp_item   (disp_item),
        .done        (done),
        .result      (result),
        .change_out  (change_out),
        .stock_empty (stock_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference state: remaining stock per item and the price list.
    int ref_stock [8];
    int price_tab [8] = '{0, 5, 10, 15, 20, 25, 30, 50};

    // Observations of the last transaction.
    int          c_lat, c_done_cnt, c_q_cyc, c_d_cyc, c_price_bad, c_stray;
    logic        c_busy0;
    logic [2:0]  c_id, c_disp_item;
    logic [1:0]  c_res;
    logic [15:0] c_chg;
    logic [7:0]  c_empty;

    // Expected outcome of one transaction from the purchase rules.
    logic [1:0]  e_res;
    logic [15:0] e_chg;
    int          e_lat, e_q, e_d;

    function automatic void model(input logic [2:0] it, input logic paid, input logic [15:0] chg);
        if (it == 0) begin
            e_res = 2'b11; e_chg = 0; e_lat = 1; e_q = 0; e_d = 0;
        end else if (ref_stock[it] == 0) begin
            e_res = 2'b10; e_chg = 0; e_lat = 1; e_q = 0; e_d = 0;
        end else if (paid) begin
            e_res = 2'b01; e_chg = chg; e_lat = 1 + WAIT + 1 + DISP; e_q = WAIT; e_d = DISP;
            ref_stock[it] = ref_stock[it] - 1;
        end else begin
            e_res = 2'b11; e_chg = 0; e_lat = 1 + WAIT + 1; e_q = WAIT; e_d = 0;
        end
    endfunction

    function automatic logic [7:0] exp_empty();
        logic [7:0] e;
        e = 8'h01;
        for (int i = 1; i < 8; i++) e[i] = (ref_stock[i] == 0);
        return e;
    endfunction

    function automatic void model_restock();
        for (int i = 0; i < 8; i++) ref_stock[i] = SINIT;
    endfunction

    // Drive one selection and watch a fixed 30-cycle window. obs j is the
    // state right after the j-th edge following the accept edge (j=0).
    task automatic run_txn(input logic [2:0] it, input logic paid, input logic [15:0] chg,
                           input int rs_at, input int sv_at, input logic [2:0] sv_item);
        @(negedge clk);
        sel_valid = 1'b1; sel_item = it; user_state = paid; user_change = chg;
        @(posedge clk);
        c_lat = -1; c_done_cnt = 0; c_q_cyc = 0; c_d_cyc = 0; c_price_bad = 0; c_stray = 0;
        c_id = '0; c_disp_item = '0; c_busy0 = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            sel_valid = 1'b0;
            restock = 1'b0;
            if (j == 0) c_busy0 = busy;
            if (user_id != 0) begin
                c_q_cyc++;
                c_id = user_id;
                if (user_price != 16'(price_tab[user_id])) c_price_bad++;
            end else if (user_price != 0) begin
                c_stray++;
            end
            if (dispense) begin
                c_d_cyc++;
                c_disp_item = disp_item;
            end else if (disp_item != 0) begin
                c_stray++;
            end
            if (done) begin
                c_done_cnt++;
                if (c_lat < 0) c_lat = j;
            end
            if (j == rs_at) restock = 1'b1;
            if (j == sv_at) begin
                sel_valid = 1'b1;
                sel_item = sv_item;
            end
        end
        c_res = result;
        c_chg = change_out;
        c_empty = stock_empty;
    endtask

    task automatic pulse_restock();
        @(negedge clk); restock = 1'b1;
        @(negedge clk); restock = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({busy, dispense, done, disp_item, user_id} !== 9'd0) begin bad++; $display("FAIL reset_ctrl got %b want 0", {busy, dispense, done, disp_item, user_id}); end
        total++; if (user_price !== 16'd0) begin bad++; $display("FAIL reset_price got %0d want 0", user_price); end
        total++; if (result !== 2'b00 || change_out !== 16'd0) begin bad++; $display("FAIL reset_result got %b/%0d want 00/0", result, change_out); end
        total++; if (stock_empty !== 8'h01) begin bad++; $display("FAIL reset_empty got %h want 01", stock_empty); end
        rst_n = 1'b1;
        model_restock();
        @(negedge clk);
    endtask

    task automatic test_buy_ok();
        model(3'd3, 1'b1, 16'd5);
        run_txn(3'd3, 1'b1, 16'd5, -1, -1, 3'd0);
        total++; if (c_busy0 !== 1'b1) begin bad++; $display("FAIL ok_busy got %b want 1", c_busy0); end
        total++; if (c_q_cyc != WAIT || c_id !== 3'd3 || c_price_bad != 0) begin bad++; $display("FAIL ok_query got cyc=%0d id=%0d badprice=%0d want cyc=%0d id=3", c_q_cyc, c_id, c_price_bad, WAIT); end
        total++; if (c_res !== e_res || c_chg !== e_chg) begin bad++; $display("FAIL ok_result got %b/%0d want %b/%0d", c_res, c_chg, e_res, e_chg); end
        total++; if (c_d_cyc != DISP || c_disp_item !== 3'd3) begin bad++; $display("FAIL ok_dispense got cyc=%0d item=%0d want %0d/3", c_d_cyc, c_disp_item, DISP); end
        total++; if (c_lat != e_lat || c_done_cnt != 1) begin bad++; $display("FAIL ok_done got lat=%0d n=%0d want %0d/1", c_lat, c_done_cnt, e_lat); end
        total++; if (c_empty !== exp_empty() || c_stray != 0) begin bad++; $display("FAIL ok_empty got %h stray=%0d want %h", c_empty, c_stray, exp_empty()); end
    endtask

    task automatic test_denied();
        model(3'd2, 1'b0, 16'd9);
        run_txn(3'd2, 1'b0, 16'd9, -1, -1, 3'd0);
        total++; if (c_res !== 2'b11 || c_chg !== 16'd0) begin bad++; $display("FAIL denied_result got %b/%0d want 11/0", c_res, c_chg); end
        total++; if (c_d_cyc != 0) begin bad++; $display("FAIL denied_nodisp got %0d want 0", c_d_cyc); end
        total++; if (c_lat != e_lat || c_q_cyc != WAIT) begin bad++; $display("FAIL denied_lat got %0d q=%0d want %0d q=%0d", c_lat, c_q_cyc, e_lat, WAIT); end
        total++; if (ref_stock[2] != SINIT || c_empty !== exp_empty()) begin bad++; $display("FAIL denied_stock got %h want %h", c_empty, exp_empty()); end
    endtask

    task automatic test_sold_out();
        for (int k = 0; k < 5; k++) begin
            model(3'd1, 1'b1, 16'(k));
            run_txn(3'd1, 1'b1, 16'(k), -1, -1, 3'd0);
            total++; if (c_res !== e_res || c_chg !== e_chg) begin bad++; $display("FAIL drain_result got %b/%0d want %b/%0d", c_res, c_chg, e_res, e_chg); end
        end
        total++; if (stock_empty[1] !== 1'b1) begin bad++; $display("FAIL drain_empty got %b want 1", stock_empty[1]); end
        model(3'd1, 1'b1, 16'd3);
        run_txn(3'd1, 1'b1, 16'd3, -1, -1, 3'd0);
        total++; if (c_res !== 2'b10 || c_chg !== 16'd0) begin bad++; $display("FAIL soldout_result got %b/%0d want 10/0", c_res, c_chg); end
        total++; if (c_q_cyc != 0 || c_d_cyc != 0 || c_stray != 0) begin bad++; $display("FAIL soldout_bus got q=%0d d=%0d stray=%0d want 0", c_q_cyc, c_d_cyc, c_stray); end
        total++; if (c_lat != 1) begin bad++; $display("FAIL soldout_lat got %0d want 1", c_lat); end
    endtask

    task automatic test_restock_idle();
        pulse_restock();
        model_restock();
        @(negedge clk);
        total++; if (stock_empty !== 8'h01) begin bad++; $display("FAIL restock_idle got %h want 01", stock_empty); end
    endtask

    task automatic test_invalid_item();
        model(3'd0, 1'b1, 16'd4);
        run_txn(3'd0, 1'b1, 16'd4, -1, -1, 3'd0);
        total++; if (c_res !== 2'b11 || c_q_cyc != 0 || c_lat != 1) begin bad++; $display("FAIL invalid got res=%b q=%0d lat=%0d want 11/0/1", c_res, c_q_cyc, c_lat); end
    endtask

    task automatic test_busy_ignore();
        model(3'd5, 1'b1, 16'd7);
        run_txn(3'd5, 1'b1, 16'd7, -1, 4, 3'd6);
        total++; if (c_done_cnt != 1 || c_disp_item !== 3'd5) begin bad++; $display("FAIL busy_ignore got done=%0d item=%0d want 1/5", c_done_cnt, c_disp_item); end
        total++; if (c_res !== 2'b01 || c_empty !== exp_empty()) begin bad++; $display("FAIL busy_ignore_state got %b/%h want 01/%h", c_res, c_empty, exp_empty()); end
    endtask

    task automatic test_restock_decide();
        model(3'd4, 1'b1, 16'd1);
        model_restock();
        run_txn(3'd4, 1'b1, 16'd1, WAIT, -1, 3'd0);
        total++; if (c_res !== 2'b01 || c_empty !== 8'h01) begin bad++; $display("FAIL restock_decide got %b/%h want 01/01", c_res, c_empty); end
        for (int k = 0; k < SINIT; k++) begin
            model(3'd4, 1'b1, 16'd0);
            run_txn(3'd4, 1'b1, 16'd0, -1, -1, 3'd0);
            total++; if (c_res !== 2'b01 || c_empty[4] !== (k == SINIT - 1)) begin bad++; $display("FAIL restock_refill got %b/%b want 01/%b", c_res, c_empty[4], (k == SINIT - 1)); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  it;
        logic        paid;
        logic [15:0] chg;
        for (int n = 0; n < 40; n++) begin
            it = 3'($urandom_range(0, 7));
            paid = ($urandom_range(0, 3) != 0);
            chg = 16'($urandom);
            model(it, paid, chg);
            run_txn(it, paid, chg, -1, -1, 3'd0);
            total++;
            if (c_res !== e_res || c_chg !== e_chg || c_lat != e_lat || c_q_cyc != e_q || c_d_cyc != e_d
                || c_done_cnt != 1 || c_price_bad != 0 || c_stray != 0 || c_empty !== exp_empty()
                || (e_q > 0 && c_id !== it) || (e_d > 0 && c_disp_item !== it)) begin
                bad++;
                $display("FAIL rand_txn item=%0d got res=%b chg=%0d lat=%0d q=%0d d=%0d n=%0d empty=%h want res=%b chg=%0d lat=%0d q=%0d d=%0d n=1 empty=%h",
                         it, c_res, c_chg, c_lat, c_q_cyc, c_d_cyc, c_done_cnt, c_empty, e_res, e_chg, e_lat, e_q, e_d, exp_empty());
            end
            if ($urandom_range(0, 9) == 0) begin
                pulse_restock();
                model_restock();
            end
        end
    endtask

    task automatic test_reset_mid_dispense();
        int seen;
        int extra;
        pulse_restock();
        model_restock();
        while (ref_stock[7] > 0) begin
            model(3'd7, 1'b1, 16'd0);
            run_txn(3'd7, 1'b1, 16'd0, -1, -1, 3'd0);
        end
        total++; if (stock_empty[7] !== 1'b1) begin bad++; $display("FAIL midrst_pre got %b want 1", stock_empty[7]); end
        @(negedge clk);
        sel_valid = 1'b1; sel_item = 3'd6; user_state = 1'b1; user_change = 16'd2;
        @(posedge clk);
        @(negedge clk);
        sel_valid = 1'b0;
        seen = 0;
        for (int j = 0; j < 20 && seen == 0; j++) begin
            if (dispense) seen = 1;
            else @(negedge clk);
        end
        total++; if (seen != 1) begin bad++; $display("FAIL midrst_disp got %0d want 1", seen); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (dispense !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midrst_abort got d=%b b=%b done=%b want 0", dispense, busy, done); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_restock();
        extra = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (done) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL midrst_done got %0d want 0", extra); end
        total++; if (stock_empty !== 8'h01 || result !== 2'b00) begin bad++; $display("FAIL midrst_stock got %h/%b want 01/00", stock_empty, result); end
    endtask

    initial begin
        test_reset();
        test_buy_ok();
        test_denied();
        test_sold_out();
        test_restock_idle();
        test_invalid_item();
        test_busy_ignore();
        test_restock_decide();
        test_random();
        test_reset_mid_dispense();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
